// File: rtl/sketch_pkg.sv
// Shared sketch pipeline definitions: element layout, bucket index extraction
// and the flush FSM state set used by the bucket stage controllers.
package sketch_pkg;

  localparam int ELEM_W     = 96;
  localparam int KEY_W      = 64;
  localparam int IDX_OFFSET = 64;

  typedef enum logic [1:0] {
    FL_RUN   = 2'd0,
    FL_DRAIN = 2'd1,
    FL_DONE  = 2'd2
  } flush_state_e;

  // Index bits sit inside the hash field, which occupies the top 32 bits.
  function automatic logic [31:0] bucket_idx(input logic [ELEM_W-1:0] elem,
                                             input int base, input int ptr);
    logic [31:0] hash;
    logic [63:0] mask;
    hash = elem[IDX_OFFSET +: 32];
    mask = (64'd1 << ptr) - 64'd1;
    return (hash >> base) & mask[31:0];
  endfunction

endpackage

// File: rtl/hazard_window.sv
// Shift register of recently issued bucket indices with a parallel compare
// against a probe index; reusable by any read-modify-write stage controller.
module hazard_window #(
  parameter int IDX_W = 10,
  parameter int DEPTH = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push_valid,
  input  logic [IDX_W-1:0] push_idx,
  input  logic [IDX_W-1:0] probe_idx,
  output logic             conflict,
  output logic             any_valid
);

  logic             ent_v   [DEPTH];
  logic [IDX_W-1:0] ent_idx [DEPTH];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        ent_v[i]   <= 1'b0;
        ent_idx[i] <= '0;
      end
    end else begin
      ent_v[0]   <= push_valid;
      ent_idx[0] <= push_idx;
      for (int i = 1; i < DEPTH; i++) begin
        ent_v[i]   <= ent_v[i-1];
        ent_idx[i] <= ent_idx[i-1];
      end
    end
  end

  always_comb begin
    conflict  = 1'b0;
    any_valid = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (ent_v[i]) begin
        any_valid = 1'b1;
        if (ent_idx[i] == probe_idx) conflict = 1'b1;
      end
    end
  end

endmodule

// File: rtl/bucket_issue_scheduler.sv
// Hazard-aware issue controller for one bucket stage, with flush handshake.
// Optional saturating stall/issue statistics are built when HAZARD_STATS_EN is defined.
module bucket_issue_scheduler
  import sketch_pkg::*;
#(
  parameter int RAM_PTR    = 10,
  parameter int HASH_BASE  = 0,
  parameter int HAZARD_WIN = 6   // 2..16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ELEM_W-1:0] in_hash_e_f,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [ELEM_W-1:0] out_hash_e_f,
  output logic              out_valid,
  input  logic              flush_req,
  output logic              flush_done,
  output logic              busy,
  output logic [31:0]       stall_cnt,
  output logic [31:0]       issue_cnt
);

  flush_state_e        state, state_nxt;
  logic                hold_valid;
  logic [ELEM_W-1:0]   hold_elem;
  logic [RAM_PTR-1:0]  hold_idx;
  logic                conflict, win_any;
  logic                issue_now, accept, run_ready;

  assign hold_idx  = RAM_PTR'(bucket_idx(hold_elem, HASH_BASE, RAM_PTR));
  assign issue_now = hold_valid && !conflict;
  // rst_n gates the handshake so nothing is taken while the block is held in reset.
  assign in_ready  = rst_n && run_ready;
  assign accept    = in_valid && in_ready;
  assign busy      = hold_valid || win_any;

  hazard_window #(
    .IDX_W (RAM_PTR),
    .DEPTH (HAZARD_WIN - 1)
  ) u_window (
    .clk        (clk),
    .rst_n      (rst_n),
    .push_valid (issue_now),
    .push_idx   (hold_idx),
    .probe_idx  (hold_idx),
    .conflict   (conflict),
    .any_valid  (win_any)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= FL_RUN;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt  = state;
    run_ready  = 1'b0;
    flush_done = 1'b0;
    case (state)
      FL_RUN: begin
        run_ready = !hold_valid || issue_now;
        if (flush_req) state_nxt = FL_DRAIN;
      end
      FL_DRAIN: begin
        if (!hold_valid && !win_any) state_nxt = FL_DONE;
      end
      FL_DONE: begin
        flush_done = 1'b1;
        if (!flush_req) state_nxt = FL_RUN;
      end
      default: state_nxt = FL_RUN;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hold_valid <= 1'b0;
      hold_elem  <= '0;
    end else if (accept) begin
      hold_valid <= 1'b1;
      hold_elem  <= in_hash_e_f;
    end else if (issue_now) begin
      hold_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid    <= 1'b0;
      out_hash_e_f <= '0;
    end else begin
      out_valid <= issue_now;
      if (issue_now) out_hash_e_f <= hold_elem;
    end
  end

`ifdef HAZARD_STATS_EN
  logic [31:0] stall_q, issue_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_q <= '0;
      issue_q <= '0;
    end else begin
      if (hold_valid && conflict && stall_q != 32'hFFFF_FFFF) stall_q <= stall_q + 32'd1;
      if (issue_now && issue_q != 32'hFFFF_FFFF)              issue_q <= issue_q + 32'd1;
    end
  end

  assign stall_cnt = stall_q;
  assign issue_cnt = issue_q;
`else
  assign stall_cnt = '0;
  assign issue_cnt = '0;
`endif

endmodule
